// File: rtl/fetch_stage_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_stage_ctrl
//   Instruction-fetch front end. Owns the PC, the instruction-memory request
//   handshake and the IF/ID pipeline register. Applies the hazard unit's
//   stall/flush controls and the EX-stage branch redirect so that the ID
//   stage sees a clean instruction stream (NOP bubbles where nothing valid).
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   Defined   : a wait counter flags fetch_err (sticky) after MAX_WAIT
//               consecutive un-acked request cycles.
//   Undefined : no counter; fetch_err is tied to 0.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   stall_IF, stall_ID    hazard-unit stalls
//   flush_ID              kill IF/ID contents and any in-flight fetch
//   EX_br_sel/_target     taken branch/jump redirect from EX
//   imem_req/_addr        fetch request and word-aligned address
//   imem_rdata/_ack       fetched instruction and one-cycle response strobe
//   ID_pc/_instr/_valid   IF/ID register outputs
//   fetch_busy            request outstanding and not acked this cycle
//   fetch_err             sticky fetch-timeout flag
// ---------------------------------------------------------------------------
module fetch_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned MAX_WAIT  = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        stall_IF,
    input  logic        stall_ID,
    input  logic        flush_ID,
    input  logic        EX_br_sel,
    input  logic [31:0] EX_br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] ID_pc,
    output logic [31:0] ID_instr,
    output logic        ID_valid,
    output logic        fetch_busy,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_KILL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] redir_q;
    logic [31:0] hold_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_instr_q;
    logic        id_valid_q;
    logic        req_q;

    logic        redirect;
    logic        ack;
    logic [31:0] target;
    logic        id_load;
    logic [31:0] id_data;

    assign redirect = flush_ID | EX_br_sel;
    assign target   = {EX_br_target[31:2], 2'b00};
    // An ack is only meaningful while a request is actually on the bus.
    assign ack      = imem_ack & req_q;

    always_comb begin
        id_load = 1'b0;
        id_data = imem_rdata;
        case (state_q)
            S_REQ:  id_load = ack & ~redirect & ~stall_IF;
            S_HOLD: begin
                id_load = ~redirect & ~stall_IF & ~stall_ID;
                id_data = hold_q;
            end
            default: id_load = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_REQ;
            pc_q       <= {RESET_PC[31:2], 2'b00};
            redir_q    <= '0;
            hold_q     <= '0;
            req_q      <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= NOP_INSTR;
            id_valid_q <= 1'b0;
        end else begin
            req_q <= 1'b1;
            case (state_q)
                S_REQ: begin
                    if (ack) begin
                        if (redirect) begin
                            pc_q <= target;
                        end else if (stall_IF) begin
                            hold_q  <= imem_rdata;
                            state_q <= S_HOLD;
                            req_q   <= 1'b0;
                        end else begin
                            pc_q <= pc_q + 32'd4;
                        end
                    end else if (redirect) begin
                        // Request stays up; its data is dropped in KILL.
                        if (req_q) begin
                            redir_q <= target;
                            state_q <= S_KILL;
                        end else begin
                            pc_q <= target;
                        end
                    end
                end
                S_KILL: begin
                    if (ack) begin
                        pc_q    <= redirect ? target : redir_q;
                        state_q <= S_REQ;
                    end else if (redirect) begin
                        redir_q <= target;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc_q    <= target;
                        state_q <= S_REQ;
                    end else if (!stall_ID && !stall_IF) begin
                        pc_q    <= pc_q + 32'd4;
                        state_q <= S_REQ;
                    end else begin
                        req_q <= 1'b0;
                    end
                end
                default: state_q <= S_REQ;
            endcase

            // IF/ID: flush beats stall beats load. An unstalled ID stage with
            // nothing new to take receives a bubble, so no instruction is
            // ever presented twice.
            if (flush_ID) begin
                id_valid_q <= 1'b0;
                id_instr_q <= NOP_INSTR;
            end else if (!stall_ID) begin
                if (id_load) begin
                    id_pc_q    <= pc_q;
                    id_instr_q <= id_data;
                    id_valid_q <= 1'b1;
                end else begin
                    id_valid_q <= 1'b0;
                    id_instr_q <= NOP_INSTR;
                end
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_q;
    logic          err_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else if (imem_ack) begin
            wait_q <= '0;
        end else if (req_q) begin
            if ({1'b0, wait_q} + (CW+1)'(1) >= (CW+1)'(MAX_WAIT)) begin
                err_q <= 1'b1;
            end
            if ({1'b0, wait_q} < (CW+1)'(MAX_WAIT)) begin
                wait_q <= wait_q + CW'(1);
            end
        end
    end

    assign fetch_err = err_q;
`else
    logic unused_max_wait;
    assign unused_max_wait = (MAX_WAIT == 0);
    assign fetch_err       = 1'b0;
`endif

    logic unused_tgt_bits;
    assign unused_tgt_bits = ^EX_br_target[1:0];

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign fetch_busy = req_q & ~imem_ack;
    assign ID_pc      = id_pc_q;
    assign ID_instr   = id_instr_q;
    assign ID_valid   = id_valid_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage_ctrl
//   Directed self-checking bench for fetch_stage_ctrl. Inputs change one time
//   unit after the rising edge; registered outputs are checked one time unit
//   after the edge, combinational outputs one unit after the inputs settle.
//   Honours FETCH_TIMEOUT_EN for the fetch_err expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_stage_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_IF, stall_ID, flush_ID, EX_br_sel;
    logic [31:0] EX_br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] ID_pc, ID_instr;
    logic        ID_valid, fetch_busy, fetch_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_stage_ctrl #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013),
        .MAX_WAIT (15)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .stall_IF    (stall_IF),
        .stall_ID    (stall_ID),
        .flush_ID    (flush_ID),
        .EX_br_sel   (EX_br_sel),
        .EX_br_target(EX_br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .ID_pc       (ID_pc),
        .ID_instr    (ID_instr),
        .ID_valid    (ID_valid),
        .fetch_busy  (fetch_busy),
        .fetch_err   (fetch_err)
    );

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        if (a == 32'h0)      return 32'h00A0_0093;
        else if (a == 32'h4) return 32'h0010_8113;
        else                 return {a[19:0], 12'h013};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; stall_IF = 0; stall_ID = 0; flush_ID = 0; EX_br_sel = 0;
        EX_br_target = '0; imem_rdata = '0; imem_ack = 0;
        #12;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
        tests++; if (ID_pc !== 32'h0) begin fails++; $display("FAIL reset_id_pc got %h exp 0", ID_pc); end
        tests++; if (ID_instr !== NOP) begin fails++; $display("FAIL reset_id_instr got %h exp %h", ID_instr, NOP); end
        tests++; if (ID_valid !== 1'b0) begin fails++; $display("FAIL reset_id_valid got %b exp 0", ID_valid); end
        tests++; if (fetch_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", fetch_busy); end
        tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", fetch_err); end
        #10 rst = 1'b0;
        tick;
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL release_req got %b exp 1", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL release_addr got %h exp 0", imem_addr); end
        tests++; if (fetch_busy !== 1'b1) begin fails++; $display("FAIL release_busy got %b exp 1", fetch_busy); end
    endtask

    // Zero-wait stream: addr 0,4,8; ID follows one cycle behind.
    task automatic test_stream;
        for (int i = 0; i < 2; i++) begin
            logic [31:0] a;
            a = 32'(i * 4);
            imem_ack = 1; imem_rdata = instr_at(a);
            #1;
            tests++; if (fetch_busy !== 1'b0) begin fails++; $display("FAIL stream_busy[%0d] got %b exp 0", i, fetch_busy); end
            tick;
            tests++; if (ID_pc !== a) begin fails++; $display("FAIL stream_id_pc[%0d] got %h exp %h", i, ID_pc, a); end
            tests++; if (ID_instr !== instr_at(a)) begin fails++; $display("FAIL stream_id_instr[%0d] got %h exp %h", i, ID_instr, instr_at(a)); end
            tests++; if (ID_valid !== 1'b1) begin fails++; $display("FAIL stream_id_valid[%0d] got %b exp 1", i, ID_valid); end
            tests++; if (imem_addr !== a + 32'd4) begin fails++; $display("FAIL stream_addr[%0d] got %h exp %h", i, imem_addr, a + 32'd4); end
        end
    endtask

    // Ack delayed 3 cycles at addr 8: request held, bubbles into ID.
    task automatic test_wait_states;
        for (int i = 0; i < 3; i++) begin
            imem_ack = 0; imem_rdata = 32'hDEAD_BEEF;
            #1;
            tests++; if (fetch_busy !== 1'b1) begin fails++; $display("FAIL wait_busy[%0d] got %b exp 1", i, fetch_busy); end
            tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin fails++; $display("FAIL wait_req[%0d] got %b/%h exp 1/00000008", i, imem_req, imem_addr); end
            tick;
            tests++; if (ID_valid !== 1'b0 || ID_instr !== NOP) begin fails++; $display("FAIL wait_bubble[%0d] got %b/%h exp 0/%h", i, ID_valid, ID_instr, NOP); end
        end
        imem_ack = 1; imem_rdata = instr_at(32'h8);
        tick;
        tests++; if (ID_pc !== 32'h8 || ID_valid !== 1'b1) begin fails++; $display("FAIL wait_done got %h/%b exp 00000008/1", ID_pc, ID_valid); end
        tests++; if (imem_addr !== 32'hC) begin fails++; $display("FAIL wait_next_addr got %h exp 0000000c", imem_addr); end
    endtask

    // Both stalls at the ack of addr 12: HOLD, ID frozen, then release.
    task automatic test_stall_hold;
        imem_ack = 1; imem_rdata = instr_at(32'hC); stall_IF = 1; stall_ID = 1;
        tick;
        imem_ack = 0; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL hold_req[%0d] got %b exp 0", i, imem_req); end
            tests++; if (ID_pc !== 32'h8 || ID_instr !== instr_at(32'h8) || ID_valid !== 1'b1) begin
                fails++; $display("FAIL hold_frozen[%0d] got %h/%h/%b exp 00000008/%h/1", i, ID_pc, ID_instr, ID_valid, instr_at(32'h8)); end
            if (i == 1) begin stall_IF = 0; stall_ID = 0; end
            tick;
        end
        tests++; if (ID_pc !== 32'hC || ID_instr !== instr_at(32'hC) || ID_valid !== 1'b1) begin
            fails++; $display("FAIL hold_release got %h/%h/%b exp 0000000c/%h/1", ID_pc, ID_instr, ID_valid, instr_at(32'hC)); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin fails++; $display("FAIL hold_next got %b/%h exp 1/00000010", imem_req, imem_addr); end
        imem_ack = 1; imem_rdata = instr_at(32'h10);
        tick;
        tests++; if (ID_pc !== 32'h10 || imem_addr !== 32'h14) begin fails++; $display("FAIL hold_after got %h/%h exp 00000010/00000014", ID_pc, imem_addr); end
    endtask

    // Redirect while addr 20 waits: KILL discards its data, next fetch 0x40.
    task automatic test_redirect_kill;
        imem_ack = 0;
        tick;
        EX_br_sel = 1; flush_ID = 1; EX_br_target = 32'h40;
        tick;
        EX_br_sel = 0; flush_ID = 0; EX_br_target = '0;
        tests++; if (ID_valid !== 1'b0) begin fails++; $display("FAIL kill_valid got %b exp 0", ID_valid); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin fails++; $display("FAIL kill_req got %b/%h exp 1/00000014", imem_req, imem_addr); end
        imem_ack = 1; imem_rdata = instr_at(32'h14);
        tick;
        tests++; if (ID_valid !== 1'b0) begin fails++; $display("FAIL kill_discard got %b exp 0", ID_valid); end
        tests++; if (imem_addr !== 32'h40) begin fails++; $display("FAIL kill_target got %h exp 00000040", imem_addr); end
        imem_rdata = instr_at(32'h40);
        tick;
        tests++; if (ID_pc !== 32'h40 || ID_instr !== instr_at(32'h40) || ID_valid !== 1'b1) begin
            fails++; $display("FAIL kill_resume got %h/%h/%b exp 00000040/%h/1", ID_pc, ID_instr, ID_valid, instr_at(32'h40)); end
    endtask

    // flush+stall_ID on a valid ID, newer redirect overwrites, PC wraps.
    task automatic test_flush_stall_wrap;
        imem_ack = 0; flush_ID = 1; stall_ID = 1; EX_br_target = 32'h80;
        tick;
        tests++; if (ID_instr !== NOP || ID_valid !== 1'b0) begin fails++; $display("FAIL flush_stall got %h/%b exp %h/0", ID_instr, ID_valid, NOP); end
        flush_ID = 0; stall_ID = 0; EX_br_sel = 1; EX_br_target = 32'hFFFF_FFFE;
        tick;
        EX_br_sel = 0; EX_br_target = '0; imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        tick;
        tests++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL kill_overwrite got %h exp fffffffc", imem_addr); end
        imem_rdata = instr_at(32'hFFFF_FFFC);
        tick;
        tests++; if (ID_pc !== 32'hFFFF_FFFC || ID_valid !== 1'b1) begin fails++; $display("FAIL wrap_id got %h/%b exp fffffffc/1", ID_pc, ID_valid); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr got %h exp 00000000", imem_addr); end
    endtask

    // Branch on an acked cycle (target low bits forced), then flush vs stall_IF.
    task automatic test_branch_flush_vs_stall;
        imem_ack = 1; imem_rdata = instr_at(32'h0); EX_br_sel = 1; EX_br_target = 32'h103;
        tick;
        EX_br_sel = 0; EX_br_target = '0;
        tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL br_ack_addr got %h exp 00000100", imem_addr); end
        imem_rdata = instr_at(32'h100);
        tick;
        tests++; if (ID_pc !== 32'h100 || ID_valid !== 1'b1) begin fails++; $display("FAIL br_ack_id got %h/%b exp 00000100/1", ID_pc, ID_valid); end
        flush_ID = 1; stall_IF = 1; EX_br_target = 32'h200; imem_rdata = instr_at(32'h104);
        tick;
        flush_ID = 0; stall_IF = 0; EX_br_target = '0; imem_ack = 0;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin fails++; $display("FAIL flush_beats_stallif got %b/%h exp 1/00000200", imem_req, imem_addr); end
        tests++; if (ID_valid !== 1'b0) begin fails++; $display("FAIL flush_beats_stallif_valid got %b exp 0", ID_valid); end
    endtask

    task automatic test_timeout;
        logic exp_err;
        imem_ack = 0;
        for (int i = 1; i <= 20; i++) begin
            tick;
`ifdef FETCH_TIMEOUT_EN
            exp_err = (i >= 15);
`else
            exp_err = 1'b0;
`endif
            tests++; if (fetch_err !== exp_err) begin fails++; $display("FAIL timeout_err[%0d] got %b exp %b", i, fetch_err, exp_err); end
        end
        tests++; if (imem_addr !== 32'h200 || imem_req !== 1'b1) begin fails++; $display("FAIL timeout_req got %b/%h exp 1/00000200", imem_req, imem_addr); end
        imem_ack = 1; imem_rdata = instr_at(32'h200);
        tick;
        imem_ack = 0;
`ifdef FETCH_TIMEOUT_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        tests++; if (fetch_err !== exp_err) begin fails++; $display("FAIL timeout_sticky got %b exp %b", fetch_err, exp_err); end
        tests++; if (ID_pc !== 32'h200 || ID_valid !== 1'b1) begin fails++; $display("FAIL timeout_fetch_continues got %h/%b exp 00000200/1", ID_pc, ID_valid); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_wait_states;
        test_stall_hold;
        test_redirect_kill;
        test_flush_stall_wrap;
        test_branch_flush_vs_stall;
        test_timeout;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage_ctrl.md
Name: fetch_stage_ctrl

Overview:
- Consumer end of the hazard/forwarding control interface.
- Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Applies stall_IF, stall_ID and flush_ID from the hazard unit, plus the branch redirect (EX_br_sel, EX_br_target), to produce a clean ID-stage instruction stream.
- Sits between the instruction memory and the ID stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction injected into the ID stage on a bubble or flush (addi x0,x0,0).
- MAX_WAIT, 15, consecutive un-acked request cycles before fetch_err is set (only used with FETCH_TIMEOUT_EN).

Ports:
- i_clk  in  1  clock; every register samples on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- stall_IF  in  1  hold the PC; do not accept a new fetch into IF/ID.
- stall_ID  in  1  hold the IF/ID register contents.
- flush_ID  in  1  kill the IF/ID contents and any in-flight fetch.
- EX_br_sel  in  1  taken branch or jump resolved in EX.
- EX_br_target  in  32  redirect PC.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_rdata  in  32  fetched instruction, valid when imem_ack=1.
- imem_ack  in  1  one-cycle response strobe.
- ID_pc  out  32  PC of the instruction in ID.
- ID_instr  out  32  instruction in ID.
- ID_valid  out  1  ID holds a real instruction.
- fetch_busy  out  1  high while a request is outstanding and un-acked.
- fetch_err  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset (async, i_rst=1):
  - pc_q=RESET_PC, state=REQ, imem_req=0.
  - ID_pc=0, ID_instr=NOP_INSTR, ID_valid=0, fetch_busy=0, fetch_err=0, wait counter=0.
- Handshake:
  - In REQ and KILL, imem_req=1 from the first cycle after reset deasserts; it stays high until the ack cycle.
  - imem_addr is stable from request assertion through ack.
  - Request in cycle n with ack in cycle n gives zero-wait fetch; throughput is one instruction per cycle.
- Redirect: a redirect is flush_ID=1 or EX_br_sel=1; the target is EX_br_target.
- State REQ (imem_req=1, imem_addr=pc_q):
  - ack and redirect: discard rdata; pc_q<=target; stay REQ.
  - ack and stall_IF: capture rdata into hold_q; go HOLD; pc_q unchanged.
  - ack otherwise: ID_instr<=rdata, ID_pc<=pc_q, ID_valid<=1; pc_q<=pc_q+4; stay REQ.
  - no ack and redirect: redir_q<=target; go KILL. The request is not withdrawn.
  - no ack otherwise: if stall_ID=0, insert a bubble (ID_valid<=0, ID_instr<=NOP_INSTR).
- State KILL (imem_req=1, imem_addr=old pc_q):
  - On ack: discard rdata; pc_q<=redir_q; go REQ.
  - A newer redirect while in KILL overwrites redir_q.
- State HOLD (imem_req=0):
  - redirect: drop hold_q; pc_q<=target; go REQ.
  - stall_ID=0 and stall_IF=0: move hold_q into ID with ID_pc=pc_q; pc_q<=pc_q+4; go REQ.
- IF/ID register precedence:
  - flush_ID forces ID_valid<=0 and ID_instr<=NOP_INSTR; it beats stall_ID and every state's write.
  - Otherwise stall_ID=1 holds ID_pc, ID_instr and ID_valid unchanged.
- Simultaneous flush_ID and stall_IF: flush wins everywhere.
- fetch_busy = imem_req & ~imem_ack (combinational).
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. pc_q[1:0] is always 0; target bits [1:0] are forced to 0.
- Reset mid-request: the outstanding fetch is abandoned. The memory side must tolerate a dropped request.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter increments on each cycle with imem_req=1 and imem_ack=0; it clears on ack or reset.
  - When the count reaches MAX_WAIT, fetch_err<=1. It stays 1 until i_rst; fetching continues.
  - The counter saturates at MAX_WAIT.
- Undefined: no counter exists; fetch_err is tied to 0.

Test Plan:
- Reset release, ack every cycle, rdata=32'h00A00093,32'h00108113,...: imem_addr 0,4,8. ID_pc follows one cycle later. ID_valid=1 from the 2nd cycle.
- Ack delayed 3 cycles at addr 8: imem_req and addr 8 held; fetch_busy=1 for 3 cycles; ID gets NOP bubbles with ID_valid=0; then ID_pc=8.
- stall_IF=stall_ID=1 for 2 cycles at the ack of addr 12: ID contents frozen, state HOLD, imem_req=0. After release, ID_pc=12 and the next fetch is addr 16.
- EX_br_sel=1, flush_ID=1, target=32'h40 while the fetch of addr 20 is waiting 2 cycles: enter KILL; addr-20 data is discarded. Next request addr 32'h40. ID_valid=0 during the flush.
- flush_ID=1 together with stall_ID=1: ID_instr=32'h00000013, ID_valid=0.
- FETCH_TIMEOUT_EN, MAX_WAIT=15, no ack for 20 cycles: fetch_err rises after the 15th un-acked cycle and stays 1 after an ack. With the macro undefined, fetch_err=0 throughout.
